alp_ctl_seq: RTL and testbench

//  Sequencer for the ALP ALU slice stack. Accepts one ALU op plus a step

---
 rtl/alp_pkg.sv | 54 +++++
 rtl/alp_ctl_dec.sv | 57 +++++
 rtl/alp_ctl_seq.sv | 125 ++++++++++++
 tb/tb_alp_ctl_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alp_pkg.sv
// Shared definitions for the ALP ALU slice sequencer.
// Contents: op encoding, FSM states, the X/Z select and first-step carry table,
// and the decoded control bundle passed from alp_ctl_dec to alp_ctl_seq.
package alp_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned XCTL_W = 4;
  localparam int unsigned ZCTL_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALP_OP_ADD   = 3'd0,
    ALP_OP_SUB   = 3'd1,
    ALP_OP_AND   = 3'd2,
    ALP_OP_OR    = 3'd3,
    ALP_OP_XOR   = 3'd4,
    ALP_OP_PASSA = 3'd5,
    ALP_OP_BADD  = 3'd6,
    ALP_OP_BSUB  = 3'd7
  } alp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alp_state_e;

  // xctl = {nA_nB,nA_pB,pA_nB,pA_pB}, zctl = {nA_pB,pA_nB,pA_pB}
  localparam logic [XCTL_W-1:0] X_ADD = 4'b0110;
  localparam logic [XCTL_W-1:0] X_SUB = 4'b1001;
  localparam logic [XCTL_W-1:0] X_AND = 4'b1110;
  localparam logic [XCTL_W-1:0] X_OR  = 4'b1000;
  localparam logic [XCTL_W-1:0] X_XOR = 4'b1001;
  localparam logic [ZCTL_W-1:0] Z_ADD = 3'b100;
  localparam logic [ZCTL_W-1:0] Z_SUB = 3'b010;
  localparam logic              CIN0_ADD = 1'b0;
  localparam logic              CIN0_SUB = 1'b1;

  // Per-op controls applied to the slice stack while running.
  typedef struct packed {
    logic [XCTL_W-1:0] xctl;
    logic [ZCTL_W-1:0] zctl;
    logic              carry_dis;
    logic              bcd_add;
    logic              bcd_op_l;
    logic              pass_a;
    logic              logic_op;   // carry flag forced to 0
  } alp_ctl_t;

  // Default carry into step 0 when no external carry is requested.
  function automatic logic op_cin0(input alp_op_e op);
    return ((op == ALP_OP_SUB) || (op == ALP_OP_BSUB)) ? CIN0_SUB : CIN0_ADD;
  endfunction

endpackage

// File: rtl/alp_ctl_dec.sv
// Combinational op -> slice control decode.
// Ports: i_op latched op code; o_ctl decoded control bundle for the RUN state.
module alp_ctl_dec
  import alp_pkg::*;
(
  input  alp_op_e  i_op,
  output alp_ctl_t o_ctl
);

  // Decimal ops reuse the binary selects and only add the BCD controls.
  always_comb begin
    o_ctl          = '0;
    o_ctl.bcd_op_l = 1'b1;
    case (i_op)
      ALP_OP_ADD: begin
        o_ctl.xctl = X_ADD;
        o_ctl.zctl = Z_ADD;
      end
      ALP_OP_SUB: begin
        o_ctl.xctl = X_SUB;
        o_ctl.zctl = Z_SUB;
      end
      ALP_OP_AND: begin
        o_ctl.xctl      = X_AND;
        o_ctl.carry_dis = 1'b1;
        o_ctl.logic_op  = 1'b1;
      end
      ALP_OP_OR: begin
        o_ctl.xctl      = X_OR;
        o_ctl.carry_dis = 1'b1;
        o_ctl.logic_op  = 1'b1;
      end
      ALP_OP_XOR: begin
        o_ctl.xctl      = X_XOR;
        o_ctl.carry_dis = 1'b1;
        o_ctl.logic_op  = 1'b1;
      end
      ALP_OP_PASSA: begin
        o_ctl.pass_a    = 1'b1;
        o_ctl.carry_dis = 1'b1;
        o_ctl.logic_op  = 1'b1;
      end
      ALP_OP_BADD: begin
        o_ctl.xctl     = X_ADD;
        o_ctl.zctl     = Z_ADD;
        o_ctl.bcd_add  = 1'b1;
        o_ctl.bcd_op_l = 1'b0;
      end
      ALP_OP_BSUB: begin
        o_ctl.xctl     = X_SUB;
        o_ctl.zctl     = Z_SUB;
        o_ctl.bcd_op_l = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alp_ctl_seq.sv
// Sequencer for the ALP ALU slice stack: runs one op for len_h steps
// (0 = 2**CNT_W), chains carry between steps and accumulates C/V/Z/N.
// Inputs: clk_h, reset_l, start_h/op_h/len_h/use_c_h/c_in_h request,
//   stall_h, alu_cout_h/alu_v_h/alu_msb_h/alu_zero_h slice status.
// Outputs: xctl_h/zctl_h selects, carry_dis_h, carry_in_h, bcd_add_h,
//   bcd_op_l, pass_a_h, busy_h, step_h, step_cnt_h, done_h, c_h/v_h/z_h/n_h.
module alp_ctl_seq
  import alp_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk_h,
  input  logic              reset_l,
  input  logic              start_h,
  input  logic [OP_W-1:0]   op_h,
  input  logic [CNT_W-1:0]  len_h,
  input  logic              use_c_h,
  input  logic              c_in_h,
  input  logic              stall_h,
  input  logic              alu_cout_h,
  input  logic              alu_v_h,
  input  logic              alu_msb_h,
  input  logic              alu_zero_h,
  output logic [XCTL_W-1:0] xctl_h,
  output logic [ZCTL_W-1:0] zctl_h,
  output logic              carry_dis_h,
  output logic              carry_in_h,
  output logic              bcd_add_h,
  output logic              bcd_op_l,
  output logic              pass_a_h,
  output logic              busy_h,
  output logic              step_h,
  output logic [CNT_W-1:0]  step_cnt_h,
  output logic              done_h,
  output logic              c_h,
  output logic              v_h,
  output logic              z_h,
  output logic              n_h
);

  alp_state_e       r_state;
  alp_op_e          r_op;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_c, r_v, r_z, r_n;

  alp_ctl_t         w_ctl;
  logic             w_run;
  logic             w_step;
  logic             w_last;

  alp_ctl_dec u_dec (
    .i_op  (r_op),
    .o_ctl (w_ctl)
  );

  assign w_run  = (r_state == ST_RUN);
  assign w_step = w_run & ~stall_h;
  // len 0 wraps to all ones, giving 2**CNT_W steps.
  assign w_last = (r_cnt == (r_len - CNT_W'(1)));

  // Controls follow the latched op in RUN, idle values otherwise.
  assign xctl_h      = w_run ? w_ctl.xctl      : '0;
  assign zctl_h      = w_run ? w_ctl.zctl      : '0;
  assign carry_dis_h = w_run ? w_ctl.carry_dis : 1'b1;
  assign carry_in_h  = w_run & ~w_ctl.carry_dis & r_carry;
  assign bcd_add_h   = w_run & w_ctl.bcd_add;
  assign bcd_op_l    = w_run ? w_ctl.bcd_op_l  : 1'b1;
  assign pass_a_h    = w_run ? w_ctl.pass_a    : 1'b1;

  assign busy_h     = (r_state != ST_IDLE);
  assign step_h     = w_step;
  assign step_cnt_h = r_cnt;
  assign done_h     = (r_state == ST_DONE);
  assign c_h        = r_c;
  assign v_h        = r_v;
  assign z_h        = r_z;
  assign n_h        = r_n;

  // Sequencer FSM, step counter, carry chain and condition-code accumulation.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
      r_op    <= ALP_OP_ADD;
      r_len   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_h) begin
            r_state <= ST_RUN;
            r_op    <= alp_op_e'(op_h);
            r_len   <= len_h;
            r_cnt   <= '0;
            r_carry <= use_c_h ? c_in_h : op_cin0(alp_op_e'(op_h));
          end
        end
        ST_RUN: begin
          if (w_step) begin
            r_carry <= alu_cout_h;
            r_c     <= w_ctl.logic_op ? 1'b0 : alu_cout_h;
            r_v     <= alu_v_h;
            r_n     <= alu_msb_h;
            r_z     <= (r_cnt == '0) ? alu_zero_h : (r_z & alu_zero_h);
            // Counter stays on the last index through DONE.
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alp_ctl_seq.sv
// Scoreboard bench for alp_ctl_seq: each op pushes its expected per-step
// controls and final flags; a negedge monitor pops on step_h / done_h.
module tb_alp_ctl_seq;

  localparam int unsigned CNT_W = 4;

  logic             clk_h = 1'b0;
  logic             reset_l;
  logic             start_h, use_c_h, c_in_h, stall_h;
  logic [2:0]       op_h;
  logic [CNT_W-1:0] len_h;
  logic             alu_cout_h, alu_v_h, alu_msb_h, alu_zero_h;
  logic [3:0]       xctl_h;
  logic [2:0]       zctl_h;
  logic             carry_dis_h, carry_in_h, bcd_add_h, bcd_op_l, pass_a_h;
  logic             busy_h, step_h, done_h, c_h, v_h, z_h, n_h;
  logic [CNT_W-1:0] step_cnt_h;

  alp_ctl_seq #(.CNT_W(CNT_W)) dut (
    .clk_h(clk_h), .reset_l(reset_l), .start_h(start_h), .op_h(op_h),
    .len_h(len_h), .use_c_h(use_c_h), .c_in_h(c_in_h), .stall_h(stall_h),
    .alu_cout_h(alu_cout_h), .alu_v_h(alu_v_h), .alu_msb_h(alu_msb_h),
    .alu_zero_h(alu_zero_h), .xctl_h(xctl_h), .zctl_h(zctl_h),
    .carry_dis_h(carry_dis_h), .carry_in_h(carry_in_h), .bcd_add_h(bcd_add_h),
    .bcd_op_l(bcd_op_l), .pass_a_h(pass_a_h), .busy_h(busy_h), .step_h(step_h),
    .step_cnt_h(step_cnt_h), .done_h(done_h), .c_h(c_h), .v_h(v_h),
    .z_h(z_h), .n_h(n_h)
  );

  always #5 clk_h = ~clk_h;

  typedef struct packed {
    logic [3:0] cnt;
    logic [3:0] x;
    logic [2:0] z;
    logic       cdis;
    logic       cin;
    logic       bcda;
    logic       bcdl;
    logic       pa;
  } step_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } done_t;

  typedef struct packed {
    logic [3:0] x;
    logic [2:0] z;
    logic       cdis;
    logic       bcda;
    logic       bcdl;
    logic       pa;
    logic       cin0;
    logic       lg;
  } ctl_exp_t;

  step_t step_q[$];
  done_t done_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc   = 0;

  always @(posedge clk_h) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-written control table for each op code.
  function automatic ctl_exp_t exp_ctl(input logic [2:0] op);
    ctl_exp_t e;
    case (op)
      3'd0:    e = '{x:4'b0110, z:3'b100, cdis:0, bcda:0, bcdl:1, pa:0, cin0:0, lg:0};
      3'd1:    e = '{x:4'b1001, z:3'b010, cdis:0, bcda:0, bcdl:1, pa:0, cin0:1, lg:0};
      3'd2:    e = '{x:4'b1110, z:3'b000, cdis:1, bcda:0, bcdl:1, pa:0, cin0:0, lg:1};
      3'd3:    e = '{x:4'b1000, z:3'b000, cdis:1, bcda:0, bcdl:1, pa:0, cin0:0, lg:1};
      3'd4:    e = '{x:4'b1001, z:3'b000, cdis:1, bcda:0, bcdl:1, pa:0, cin0:0, lg:1};
      3'd5:    e = '{x:4'b0000, z:3'b000, cdis:1, bcda:0, bcdl:1, pa:1, cin0:0, lg:1};
      3'd6:    e = '{x:4'b0110, z:3'b100, cdis:0, bcda:1, bcdl:0, pa:0, cin0:0, lg:0};
      default: e = '{x:4'b1001, z:3'b010, cdis:0, bcda:0, bcdl:0, pa:0, cin0:1, lg:0};
    endcase
    return e;
  endfunction

  // Monitor: pops one expected record per observed step_h / done_h.
  always @(negedge clk_h) begin : mon
    step_t sa, se;
    done_t da, de;
    if (step_h === 1'b1) begin
      sa = '{cnt:step_cnt_h, x:xctl_h, z:zctl_h, cdis:carry_dis_h, cin:carry_in_h,
             bcda:bcd_add_h, bcdl:bcd_op_l, pa:pass_a_h};
      if (step_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL step_unexpected: step_h=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        se = step_q.pop_front();
        chk("step{cnt,x,z,cdis,cin,bcda,bcdl,pa}", 64'(sa), 64'(se));
      end
    end
    if (done_h === 1'b1) begin
      da = '{cyc:32'(cyc), c:c_h, v:v_h, z:z_h, n:n_h};
      if (done_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done_unexpected: done_h=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        de = done_q.pop_front();
        chk("done{cyc,c,v,z,n}", 64'(da), 64'(de));
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy_h), 64'(0));
    chk({tag, "_ctl{x,z,cdis,cin,bcda,bcdl,pa,step,done}"},
        64'({xctl_h, zctl_h, carry_dis_h, carry_in_h, bcd_add_h, bcd_op_l, pass_a_h, step_h, done_h}),
        64'({4'b0000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
  endtask

  // Issue one op; caller is at posedge+1. Returns at posedge+1 back in IDLE.
  task automatic run_op(input logic [2:0] op, input logic [3:0] len, input logic uc,
                        input logic ci, input logic [15:0] co, input logic [15:0] vv,
                        input logic [15:0] ms, input logic [15:0] zr,
                        input int stall_step, input int stall_n,
                        input bit restart, input bit stall_idle);
    int       n;
    ctl_exp_t e;
    logic     cin;
    logic     zacc;
    n    = (len == 4'd0) ? 16 : int'(len);
    e    = exp_ctl(op);
    zacc = 1'b1;
    for (int k = 0; k < n; k++) begin
      cin = (k == 0) ? (uc ? ci : e.cin0) : co[k-1];
      if (e.cdis) cin = 1'b0;
      step_q.push_back('{cnt:4'(k), x:e.x, z:e.z, cdis:e.cdis, cin:cin,
                         bcda:e.bcda, bcdl:e.bcdl, pa:e.pa});
      zacc = zacc & zr[k];
    end
    done_q.push_back('{cyc:32'(cyc + 1 + n + stall_n), c:(e.lg ? 1'b0 : co[n-1]),
                       v:vv[n-1], z:zacc, n:ms[n-1]});
    start_h = 1'b1; op_h = op; len_h = len; use_c_h = uc; c_in_h = ci;
    stall_h = stall_idle;
    @(posedge clk_h); #1;
    stall_h = 1'b0;
    op_h = ~op; use_c_h = ~uc; c_in_h = ~ci;
    for (int k = 0; k < n; k++) begin
      start_h = (restart && k == 0);
      if (restart && k == 0) begin
        op_h = 3'd5; len_h = 4'd1;
      end
      alu_cout_h = co[k]; alu_v_h = vv[k]; alu_msb_h = ms[k]; alu_zero_h = zr[k];
      if (k == stall_step) begin
        repeat (stall_n) begin
          stall_h = 1'b1;
          #1;
          chk("stall_step_h", 64'(step_h), 64'(0));
          chk("stall_cnt", 64'(step_cnt_h), 64'(k));
          chk("stall_ctl{busy,bcda,bcdl,x}", 64'({busy_h, bcd_add_h, bcd_op_l, xctl_h}),
              64'({1'b1, e.bcda, e.bcdl, e.x}));
          @(posedge clk_h); #1;
        end
        stall_h = 1'b0;
      end
      @(posedge clk_h); #1;
    end
    start_h = 1'b0;
    stall_h = stall_idle;
    alu_cout_h = 1'b0; alu_v_h = 1'b0; alu_msb_h = 1'b0; alu_zero_h = 1'b0;
    chk("done_cnt_hold", 64'(step_cnt_h), 64'(n - 1));
    @(posedge clk_h); #1;
    stall_h = 1'b0;
    check_idle("post_op");
  endtask

  // Reset in the middle of step 1: only step 0 is expected, no done_h.
  task automatic abort_op();
    step_q.push_back('{cnt:4'd0, x:4'b0110, z:3'b100, cdis:1'b0, cin:1'b0,
                       bcda:1'b0, bcdl:1'b1, pa:1'b0});
    start_h = 1'b1; op_h = 3'd0; len_h = 4'd3; use_c_h = 1'b0; c_in_h = 1'b0;
    @(posedge clk_h); #1;
    start_h = 1'b0;
    alu_cout_h = 1'b1; alu_v_h = 1'b1; alu_msb_h = 1'b1; alu_zero_h = 1'b1;
    @(posedge clk_h); #1;
    chk("abort_pre_flags{c,v,z,n}", 64'({c_h, v_h, z_h, n_h}), 64'(4'b1111));
    reset_l = 1'b0;
    #1;
    check_idle("abort");
    chk("abort_flags{c,v,z,n}", 64'({c_h, v_h, z_h, n_h}), 64'(0));
    chk("abort_cnt", 64'(step_cnt_h), 64'(0));
    alu_cout_h = 1'b0; alu_v_h = 1'b0; alu_msb_h = 1'b0; alu_zero_h = 1'b0;
    repeat (2) @(posedge clk_h);
    #1;
    reset_l = 1'b1;
    repeat (4) @(posedge clk_h);
    #1;
    check_idle("after_abort");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b0; start_h = 1'b0; op_h = 3'd0; len_h = '0; use_c_h = 1'b0;
    c_in_h = 1'b0; stall_h = 1'b0; alu_cout_h = 1'b0; alu_v_h = 1'b0;
    alu_msb_h = 1'b0; alu_zero_h = 1'b0;
    repeat (3) @(posedge clk_h);
    #1;
    check_idle("reset");
    chk("reset_cnt", 64'(step_cnt_h), 64'(0));
    chk("reset_flags{c,v,z,n}", 64'({c_h, v_h, z_h, n_h}), 64'(0));
    reset_l = 1'b1;
    @(posedge clk_h); #1;

    // 1) ADD len 3: carry chain 1,0,1 -> carry_in 0,1,0, c=1
    run_op(3'd0, 4'd3, 1'b0, 1'b0, 16'b101, 16'b010, 16'b001, 16'b000, -1, 0, 1'b0, 1'b0);
    // 2) SUB len 1 with stall held in IDLE/DONE: carry_in 1, c=0
    run_op(3'd1, 4'd1, 1'b0, 1'b0, 16'b0, 16'b1, 16'b1, 16'b1, -1, 0, 1'b0, 1'b1);
    // external carry-in overrides op default
    run_op(3'd1, 4'd2, 1'b1, 1'b0, 16'b11, 16'b00, 16'b10, 16'b00, -1, 0, 1'b0, 1'b0);
    // 3) AND len 2: zero 1,0 -> z=0; then zero 1,1 -> z=1; carry forced 0
    run_op(3'd2, 4'd2, 1'b1, 1'b1, 16'b11, 16'b00, 16'b00, 16'b01, -1, 0, 1'b0, 1'b0);
    run_op(3'd2, 4'd2, 1'b0, 1'b0, 16'b11, 16'b10, 16'b01, 16'b11, -1, 0, 1'b0, 1'b0);
    run_op(3'd3, 4'd1, 1'b0, 1'b0, 16'b1, 16'b0, 16'b1, 16'b0, -1, 0, 1'b0, 1'b0);
    run_op(3'd4, 4'd1, 1'b0, 1'b0, 16'b1, 16'b1, 16'b0, 16'b1, -1, 0, 1'b0, 1'b0);
    run_op(3'd5, 4'd2, 1'b1, 1'b1, 16'b11, 16'b00, 16'b11, 16'b11, -1, 0, 1'b0, 1'b0);
    // 4) BADD len 2 with a 2-cycle stall in step 1
    run_op(3'd6, 4'd2, 1'b0, 1'b0, 16'b01, 16'b01, 16'b10, 16'b11, 1, 2, 1'b0, 1'b0);
    run_op(3'd7, 4'd2, 1'b0, 1'b0, 16'b10, 16'b10, 16'b00, 16'b10, -1, 0, 1'b0, 1'b0);
    // 5) start_h during RUN ignored; reset mid-step aborts
    run_op(3'd0, 4'd2, 1'b1, 1'b1, 16'b10, 16'b00, 16'b01, 16'b00, -1, 0, 1'b1, 1'b0);
    abort_op();
    // 6) len 0 runs 16 steps
    run_op(3'd0, 4'd0, 1'b0, 1'b0, 16'hA5C3, 16'h8001, 16'h7FFE, 16'hFFFF, -1, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk_h);
    #1;
    chk("step_q_empty", 64'(step_q.size()), 64'(0));
    chk("done_q_empty", 64'(done_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
